// File: rtl/sp_dispatch_pkg.sv
// Shared types and constants for the scratchpad instruction dispatch front end.
package sp_dispatch_pkg;

    localparam logic [1:0]  OP_GEMM        = 2'd3;
    localparam int unsigned NEW_WEIGHT_BIT = 3;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [3:0]  flags;
        logic [31:0] payload;
    } instr_t;

    typedef enum logic {IDLE, BUSY} arb_state_t;

endpackage

// File: rtl/sp_instr_dispatch_if.sv
// Bundle of instruction-queue, bank join and DRAM load signals for sp_instr_dispatch.
interface sp_instr_dispatch_if #(
    parameter int unsigned NUM_BANKS   = 4,
    parameter int unsigned INSTR_DEPTH = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MAT_W       = 6,
    parameter int unsigned INSTR_W     = 38
);
    localparam int unsigned CNT_W = $clog2(INSTR_DEPTH) + 1;

    logic                        instr_valid;
    logic [INSTR_W-1:0]          instr_wdata;
    logic                        instr_ready;
    logic [CNT_W-1:0]            instr_count;
    logic                        head_valid;
    logic [INSTR_W-1:0]          head_data;
    logic                        head_new;
    logic [NUM_BANKS-1:0]        bank_accept;
    logic                        new_weight;
    logic [MAT_W-1:0]            gemm_mat;
    logic [NUM_BANKS-1:0]        bank_load_req;
    logic [NUM_BANKS*ADDR_W-1:0] bank_load_addr;
    logic [NUM_BANKS-1:0]        load_grant;
    logic [NUM_BANKS-1:0]        load_done;
    logic                        sLoad;
    logic [ADDR_W-1:0]           load_addr;
    logic                        sLoad_hit;

    modport slave (
        input  instr_valid, instr_wdata, bank_accept, bank_load_req, bank_load_addr, sLoad_hit,
        output instr_ready, instr_count, head_valid, head_data, head_new, new_weight, gemm_mat,
               load_grant, load_done, sLoad, load_addr
    );

    modport master (
        output instr_valid, instr_wdata, bank_accept, bank_load_req, bank_load_addr, sLoad_hit,
        input  instr_ready, instr_count, head_valid, head_data, head_new, new_weight, gemm_mat,
               load_grant, load_done, sLoad, load_addr
    );

endinterface

// File: rtl/sp_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module sp_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned p, input int unsigned k);
        int unsigned s;
        s = p + k;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!o_valid && i_req[wrap_idx(int'(i_ptr), k)]) begin
                o_valid                         = 1'b1;
                o_idx                           = wrap_idx(int'(i_ptr), k);
                o_gnt[wrap_idx(int'(i_ptr), k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_instr_dispatch.sv
// Scratchpad front end: instruction FIFO with multi-bank join, GEMM matrix tracking and a
// round-robin DRAM load arbiter that holds each grant until the memory side reports a hit.
module sp_instr_dispatch
    import sp_dispatch_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = 4,
    parameter int unsigned INSTR_DEPTH = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MAT_W       = 6,
    parameter int unsigned INSTR_W     = 38
) (
    input logic                CLK,
    input logic                RST,
    sp_instr_dispatch_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(INSTR_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = $clog2(NUM_BANKS);

    // Instruction FIFO and join state
    logic [INSTR_W-1:0]   r_mem [INSTR_DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_seen;
    logic [NUM_BANKS-1:0] r_taken;
    logic [MAT_W-1:0]     r_gemm;

    logic   w_full;
    logic   w_head_valid;
    logic   w_head_new;
    logic   w_all_acc;
    logic   w_push;
    logic   w_pop;
    instr_t w_head;

    assign w_full       = (r_count == CNT_W'(INSTR_DEPTH));
    assign w_head_valid = (r_count != '0);
    assign w_head       = instr_t'(r_mem[r_rptr]);
    assign w_head_new   = w_head_valid && !r_seen;
    assign w_all_acc    = &(r_taken | bus.bank_accept);
    assign w_push       = bus.instr_valid && !w_full;
    assign w_pop        = w_head_valid && w_all_acc;

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr] <= bus.instr_wdata;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_seen  <= 1'b0;
            r_taken <= '0;
            r_gemm  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            // Accepts only accumulate against a presented head; the pop clears the join.
            if (w_pop) begin
                r_seen  <= 1'b0;
                r_taken <= '0;
            end else if (w_head_valid) begin
                r_seen  <= 1'b1;
                r_taken <= r_taken | bus.bank_accept;
            end
            if (w_head_new && w_head.opcode == OP_GEMM) begin
                r_gemm <= w_head.payload[MAT_W-1:0];
            end
        end
    end

    assign bus.instr_ready = !w_full;
    assign bus.instr_count = r_count;
    assign bus.head_valid  = w_head_valid;
    assign bus.head_data   = r_mem[r_rptr];
    assign bus.head_new    = w_head_new;
    assign bus.new_weight  = w_head_new && (w_head.opcode == OP_GEMM) &&
                             w_head.flags[NEW_WEIGHT_BIT];
    assign bus.gemm_mat    = r_gemm;

    // Load arbiter
    arb_state_t           r_state;
    logic [NUM_BANKS-1:0] r_grant;
    logic [IDX_W-1:0]     r_grant_idx;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [ADDR_W-1:0]    r_load_addr;
    logic                 r_sload;

    logic [NUM_BANKS-1:0] w_arb_gnt;
    logic [IDX_W-1:0]     w_arb_idx;
    logic                 w_arb_valid;
    logic [ADDR_W-1:0]    w_sel_addr;

    sp_rr_arbiter #(
        .N(NUM_BANKS)
    ) u_rr_arbiter (
        .i_req  (bus.bank_load_req),
        .i_ptr  (r_rr_ptr),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx),
        .o_valid(w_arb_valid)
    );

    always_comb begin
        w_sel_addr = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (w_arb_idx == IDX_W'(i)) w_sel_addr = bus.bank_load_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_load_addr <= '0;
            r_sload     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_grant     <= w_arb_gnt;
                        r_grant_idx <= w_arb_idx;
                        r_load_addr <= w_sel_addr;
                        r_sload     <= 1'b1;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.sLoad_hit) begin
                        r_grant     <= '0;
                        r_load_addr <= '0;
                        r_sload     <= 1'b0;
                        r_rr_ptr    <= (r_grant_idx == IDX_W'(NUM_BANKS - 1)) ? '0 :
                                       r_grant_idx + IDX_W'(1);
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.load_grant = r_grant;
    assign bus.load_done  = r_grant & {NUM_BANKS{r_sload && bus.sLoad_hit}};
    assign bus.sLoad      = r_sload;
    assign bus.load_addr  = r_load_addr;

endmodule

// File: tb/tb_sp_instr_dispatch.sv
// Randomised scoreboard bench for sp_instr_dispatch: FIFO/join model plus round-robin load model.
module tb_sp_instr_dispatch;
    import sp_dispatch_pkg::*;

    localparam int NB = 4;
    localparam int DEPTH = 4;
    localparam int AW = 32;
    localparam int MW = 6;
    localparam int IW = 38;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sp_instr_dispatch_if #(.NUM_BANKS(NB), .INSTR_DEPTH(DEPTH), .ADDR_W(AW), .MAT_W(MW),
                           .INSTR_W(IW)) bus ();

    sp_instr_dispatch #(.NUM_BANKS(NB), .INSTR_DEPTH(DEPTH), .ADDR_W(AW), .MAT_W(MW),
                        .INSTR_W(IW)) dut (.CLK(clk), .RST(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO reference: queue of contents, set of banks that accepted the head
    instr_t          m_q[$];
    instr_t          exp_q[$];
    logic [NB-1:0]   m_taken = '0;
    logic [MW-1:0]   m_gemm = '0;

    function automatic instr_t rand_instr();
        instr_t r;
        r.opcode  = 2'($urandom_range(3));
        r.flags   = 4'($urandom);
        r.payload = $urandom;
        return r;
    endfunction

    task automatic step(input bit push, input instr_t d, input logic [NB-1:0] acc);
        bit do_pop;
        bit do_push;
        @(negedge clk);
        chk("instr_ready", 64'(bus.instr_ready), 64'(m_q.size() < DEPTH));
        chk("instr_count", 64'(bus.instr_count), 64'(m_q.size()));
        chk("head_valid", 64'(bus.head_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) chk("head_data", 64'(bus.head_data), 64'(m_q[0]));
        bus.instr_valid = push;
        bus.instr_wdata = d;
        bus.bank_accept = acc;
        do_pop  = (m_q.size() > 0) && ((m_taken | acc) == '1);
        do_push = push && (m_q.size() < DEPTH);
        if (do_push) exp_q.push_back(d);
        @(posedge clk);
        if (do_pop) begin
            void'(m_q.pop_front());
            m_taken = '0;
        end else if (m_q.size() > 0) begin
            m_taken = m_taken | acc;
        end
        if (do_push) m_q.push_back(d);
    endtask

    // Head monitor: every head is presented exactly once, in push order
    initial begin : head_mon
        instr_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.head_new === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_head: got unexpected head %0h expected none", bus.head_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_head", 64'(bus.head_data), 64'(e));
                    chk("sb_new_weight", 64'(bus.new_weight),
                        64'(e.opcode == OP_GEMM && e.flags[NEW_WEIGHT_BIT]));
                    chk("sb_gemm_mat", 64'(bus.gemm_mat), 64'(m_gemm));
                    if (e.opcode == OP_GEMM) m_gemm = e.payload[MW-1:0];
                end
            end else if (!rst) begin
                chk("new_weight_idle", 64'(bus.new_weight), 64'(0));
            end
        end
    end

    // Bank/memory model and load scoreboard
    logic [NB-1:0]   l_req = '0;
    logic [NB-1:0]   l_cool = '0;
    logic [NB-1:0]   p_req = '0;
    logic [AW-1:0]   l_addr[NB];
    logic [AW-1:0]   p_addr[NB];
    logic [AW-1:0]   cur_addr = '0;
    int              rr = 0;
    int              cur = 0;
    bit              p_sload = 1'b0;
    int unsigned     req_pct = 0;
    int unsigned     hit_pct = 0;
    bit              hit_force = 1'b0;
    bit              perturb = 1'b0;
    int              grant_log[$];

    function automatic int pick(input logic [NB-1:0] r, input int p);
        for (int k = 0; k < NB; k++) begin
            if (r[(p + k) % NB]) return (p + k) % NB;
        end
        return -1;
    endfunction

    initial begin : load_model
        logic            hit;
        logic [NB*AW-1:0] flat;
        for (int i = 0; i < NB; i++) begin
            l_addr[i] = '0;
            p_addr[i] = '0;
        end
        bus.bank_load_req  = '0;
        bus.bank_load_addr = '0;
        bus.sLoad_hit      = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                l_req = '0; l_cool = '0; p_req = '0; rr = 0; p_sload = 1'b0;
                bus.bank_load_req = '0;
                bus.sLoad_hit     = 1'b0;
                continue;
            end
            for (int i = 0; i < NB; i++) begin
                if (!l_req[i] && !l_cool[i] && $urandom_range(99) < req_pct) begin
                    l_req[i]  = 1'b1;
                    l_addr[i] = $urandom;
                end else if (l_req[i] && perturb && $urandom_range(3) == 0) begin
                    l_addr[i] = $urandom;
                end
            end
            l_cool = '0;
            hit = bus.sLoad && (hit_force || $urandom_range(99) < hit_pct);
            for (int i = 0; i < NB; i++) flat[i*AW +: AW] = l_addr[i];
            bus.bank_load_req  = l_req;
            bus.bank_load_addr = flat;
            bus.sLoad_hit      = hit;
            #1;
            if (bus.sLoad && !p_sload) begin
                cur = pick(p_req, rr);
                if (cur < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_spurious: got grant %0h expected none", bus.load_grant);
                end else begin
                    cur_addr = p_addr[cur];
                    grant_log.push_back(cur);
                end
            end else if (!p_sload && p_req != '0) begin
                chk("grant_issued", 64'(bus.sLoad), 64'(1));
            end
            if (bus.sLoad) begin
                chk("load_grant", 64'(bus.load_grant), 64'(1) << cur);
                chk("load_addr", 64'(bus.load_addr), 64'(cur_addr));
            end else begin
                chk("idle_grant", 64'(bus.load_grant), 64'(0));
                chk("idle_addr", 64'(bus.load_addr), 64'(0));
            end
            chk("load_done", 64'(bus.load_done), (hit && bus.sLoad) ? (64'(1) << cur) : 64'(0));
            p_sload = bus.sLoad;
            p_req   = l_req;
            for (int i = 0; i < NB; i++) p_addr[i] = l_addr[i];
            if (hit && bus.sLoad) begin
                rr          = (cur + 1) % NB;
                l_req[cur]  = 1'b0;
                l_cool[cur] = 1'b1;
            end
        end
    end

    task automatic wait_grants(input int want, input int budget);
        int n = 0;
        while (grant_log.size() < want && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("grant_wait", 64'(grant_log.size() >= want), 64'(1));
    endtask

    task automatic wait_load_idle(input int budget);
        int n = 0;
        while ((bus.sLoad || l_req != '0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("load_drain", 64'(bus.sLoad || l_req != '0), 64'(0));
    endtask

    initial begin : main
        instr_t g;
        int     n;
        bus.instr_valid = 1'b0;
        bus.instr_wdata = '0;
        bus.bank_accept = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(bus.instr_ready), 64'(1));
        chk("rst_count", 64'(bus.instr_count), 64'(0));
        chk("rst_head_valid", 64'(bus.head_valid), 64'(0));
        chk("rst_head_new", 64'(bus.head_new), 64'(0));
        chk("rst_gemm", 64'(bus.gemm_mat), 64'(0));
        chk("rst_sload", 64'(bus.sLoad), 64'(0));
        chk("rst_done", 64'(bus.load_done), 64'(0));

        // GEMM head accepted by all banks in its first cycle
        g.opcode = OP_GEMM; g.flags = 4'b1000; g.payload = 32'h15;
        step(1'b1, g, '0);
        step(1'b0, '0, '1);
        step(1'b0, '0, '0);
        chk("gemm_mat_15", 64'(bus.gemm_mat), 64'(6'h15));

        // Staggered accepts 2,0,2,3,1
        g.opcode = 2'd1; g.flags = 4'b1000; g.payload = 32'hABCD;
        step(1'b1, g, '0);
        step(1'b0, '0, 4'b0100);
        step(1'b0, '0, 4'b0001);
        step(1'b0, '0, 4'b0100);
        step(1'b0, '0, 4'b1000);
        step(1'b0, '0, 4'b0010);
        step(1'b0, '0, '0);
        chk("join_count", 64'(bus.instr_count), 64'(0));

        // Fill, overflow, pop-while-full, drain across pointer wrap
        for (int i = 0; i < 5; i++) begin
            g = rand_instr();
            g.opcode = 2'd0;
            step(1'b1, g, '0);
        end
        for (int i = 0; i < 6; i++) begin
            g = rand_instr();
            g.opcode = 2'd2;
            step(1'b1, g, '1);
        end
        n = 0;
        while (m_q.size() > 0 && n < 12) begin
            step(1'b0, '0, '1);
            n++;
        end
        step(1'b0, '0, '0);
        chk("drain_count", 64'(bus.instr_count), 64'(0));

        // Banks 1 and 3 request, manual hit timing
        @(posedge clk);
        l_addr[1] = 32'h1000;
        l_addr[3] = 32'h3000;
        l_req     = 4'b1010;
        repeat (3) @(posedge clk);
        #1;
        chk("dir_grant1", 64'(bus.load_grant), 64'(4'b0010));
        chk("dir_addr1", 64'(bus.load_addr), 64'(32'h1000));
        hit_force = 1'b1;
        @(posedge clk);
        hit_force = 1'b0;
        wait_grants(2, 20);
        #1;
        chk("dir_addr3", 64'(bus.load_addr), 64'(32'h3000));
        if (grant_log.size() >= 2) begin
            chk("dir_order0", 64'(grant_log[0]), 64'(1));
            chk("dir_order1", 64'(grant_log[1]), 64'(3));
        end
        @(posedge clk);
        hit_force = 1'b1;
        @(posedge clk);
        hit_force = 1'b0;
        wait_load_idle(20);

        // All banks requesting continuously
        grant_log.delete();
        req_pct = 100;
        hit_pct = 40;
        wait_grants(5, 300);
        if (grant_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", 64'(grant_log[i]), 64'(i % NB));
        end
        req_pct = 0;
        hit_pct = 100;
        wait_load_idle(50);
        hit_pct = 0;

        // Reset during BUSY with two FIFO entries
        step(1'b1, rand_instr(), '0);
        step(1'b1, rand_instr(), '0);
        step(1'b0, '0, '0);
        @(posedge clk);
        l_addr[2] = 32'h2222;
        l_req     = 4'b0100;
        n = 0;
        while (!bus.sLoad && n < 10) begin
            @(posedge clk);
            n++;
        end
        chk("pre_rst_busy", 64'(bus.sLoad), 64'(1));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_sload", 64'(bus.sLoad), 64'(0));
        chk("rst_mid_count", 64'(bus.instr_count), 64'(0));
        chk("rst_mid_gemm", 64'(bus.gemm_mat), 64'(0));
        chk("rst_mid_ready", 64'(bus.instr_ready), 64'(1));
        chk("rst_mid_done", 64'(bus.load_done), 64'(0));
        m_q.delete();
        exp_q.delete();
        m_taken = '0;
        m_gemm  = '0;
        grant_log.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        l_addr[2] = 32'h2000;
        l_addr[3] = 32'h3000;
        l_req     = 4'b1100;
        wait_grants(1, 20);
        if (grant_log.size() >= 1) chk("post_rst_grant", 64'(grant_log[0]), 64'(2));
        hit_pct = 100;
        wait_load_idle(50);

        // Random traffic on both sides
        perturb = 1'b1;
        req_pct = 30;
        hit_pct = 30;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) < 60, rand_instr(), NB'($urandom));
        end
        n = 0;
        while (m_q.size() > 0 && n < 20) begin
            step(1'b0, '0, '1);
            n++;
        end
        step(1'b0, '0, '0);
        chk("final_count", 64'(bus.instr_count), 64'(0));
        chk("final_sb_empty", 64'(exp_q.size()), 64'(0));
        req_pct = 0;
        hit_pct = 100;
        wait_load_idle(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
